// File: rtl/light_zone_scheduler_pkg.sv
// Shared types and helpers for the lighting-budget scheduler: zone state
// encodings, default brightness threshold and the lit-count width helper.
package light_zone_scheduler_pkg;

  typedef enum logic [1:0] {
    ZONE_OFF  = 2'd0,
    ZONE_ON   = 2'd1,
    ZONE_HOLD = 2'd2
  } zone_state_e;

  localparam logic [7:0] DEF_LUM_THRESH = 8'h40;

  function automatic int count_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/light_zone_scheduler_zone_fsm.sv
// Per-zone OFF/ON/HOLD controller: turns on when granted and keeps the light
// on for HOLD_CYCLES cycles after the effective request drops.
module zone_fsm
  import light_zone_scheduler_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic grant,
  input  logic eff_req,
  output logic lit,
  output logic is_off,
  output logic lit_next
);

  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  zone_state_e   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      ZONE_OFF: if (grant) state_d = ZONE_ON;
      ZONE_ON: begin
        if (!eff_req) begin
          state_d = ZONE_HOLD;
          timer_d = TW'(HOLD_CYCLES - 1);
        end
      end
      ZONE_HOLD: begin
        if (eff_req)             state_d = ZONE_ON;
        else if (timer_q == '0)  state_d = ZONE_OFF;
        else                     timer_d = timer_q - TW'(1);
      end
      default: state_d = ZONE_OFF;
    endcase
  end

  // Only the state is reset; the timer is always reloaded on entry to HOLD.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ZONE_OFF;
    else       state_q <= state_d;
    timer_q <= timer_d;
  end

  assign lit      = (state_q != ZONE_OFF);
  assign is_off   = (state_q == ZONE_OFF);
  assign lit_next = (state_d != ZONE_OFF);

endmodule

// File: rtl/light_zone_scheduler.sv
// Shares a lighting power budget among zones: at most MAX_ON lit, one new
// grant per cycle, manual requests first, round-robin within a class.
module light_zone_scheduler
  import light_zone_scheduler_pkg::*;
#(
  parameter int         N_ZONES     = 4,
  parameter int         MAX_ON      = 2,
  parameter int         HOLD_CYCLES = 4,
  parameter logic [7:0] LUM_THRESH  = DEF_LUM_THRESH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_ZONES-1:0]            zone_req,
  input  logic [N_ZONES-1:0]            zone_manual,
  input  logic [7:0]                    lum_sen,
  output logic [N_ZONES-1:0]            zone_light,
  output logic [N_ZONES-1:0]            zone_wait,
  output logic [count_w(N_ZONES)-1:0]   on_count
);

  localparam int CW = count_w(N_ZONES);
  localparam int PW = $clog2(N_ZONES);

  logic [N_ZONES-1:0] eff_req, off, lit, lit_next, grant, elig, cand;
  logic [N_ZONES-1:0] zone_wait_q, zone_wait_d;
  logic [CW-1:0]      on_count_q, on_count_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;

  function automatic logic [CW-1:0] popcount(input logic [N_ZONES-1:0] v);
    logic [CW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < N_ZONES; i++) cnt = cnt + CW'(v[i]);
    return cnt;
  endfunction

  assign eff_req = zone_manual | (zone_req & {N_ZONES{lum_sen < LUM_THRESH}});

  for (genvar g = 0; g < N_ZONES; g++) begin : g_zone
    zone_fsm #(.HOLD_CYCLES(HOLD_CYCLES)) u_zone (
      .clk      (clk),
      .reset    (reset),
      .grant    (grant[g]),
      .eff_req  (eff_req[g]),
      .lit      (lit[g]),
      .is_off   (off[g]),
      .lit_next (lit_next[g])
    );
  end

  // Budget check uses the registered count, so a slot freed this edge is
  // only reusable from the following cycle.
  always_comb begin
    logic found;
    int   idx;
    found    = 1'b0;
    idx      = 0;
    grant    = '0;
    rr_ptr_d = rr_ptr_q;
    elig     = (on_count_q < CW'(MAX_ON)) ? (eff_req & off) : '0;
    cand     = (|(elig & zone_manual)) ? (elig & zone_manual) : elig;
    for (int k = 0; k < N_ZONES; k++) begin
      idx = (int'(rr_ptr_q) + k) % N_ZONES;
      if (!found && cand[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        rr_ptr_d   = PW'((idx + 1) % N_ZONES);
      end
    end
  end

  assign zone_wait_d = eff_req & off & ~grant;
  assign on_count_d  = popcount(lit_next);

  always_ff @(posedge clk) begin
    if (reset) begin
      zone_wait_q <= '0;
      on_count_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      zone_wait_q <= zone_wait_d;
      on_count_q  <= on_count_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign zone_light = lit;
  assign zone_wait  = zone_wait_q;
  assign on_count   = on_count_q;

endmodule

// File: tb/tb_light_zone_scheduler.sv
// Directed bench for light_zone_scheduler (4 zones, budget 2, hold 4, thresh 0x40).
module tb_light_zone_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] zone_req, zone_manual, zone_light, zone_wait;
  logic [7:0] lum_sen;
  logic [2:0] on_count;

  int checks = 0;
  int errors = 0;

  light_zone_scheduler #(
    .N_ZONES(4), .MAX_ON(2), .HOLD_CYCLES(4), .LUM_THRESH(8'h40)
  ) dut (
    .clk(clk), .reset(reset), .zone_req(zone_req), .zone_manual(zone_manual),
    .lum_sen(lum_sen), .zone_light(zone_light), .zone_wait(zone_wait),
    .on_count(on_count)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] l, input logic [3:0] w,
                         input logic [2:0] c);
    chk({tag, "_light"}, {4'h0, zone_light}, {4'h0, l});
    chk({tag, "_wait"},  {4'h0, zone_wait},  {4'h0, w});
    chk({tag, "_count"}, {5'h0, on_count},   {5'h0, c});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; zone_req = 4'hF; zone_manual = 4'h0; lum_sen = 8'h10;

    // Reset held for three edges with all auto requests active
    tick(3);
    chk_all("reset", 4'b0000, 4'b0000, 3'd0);

    // Single pulse: lit one edge later, then HOLD for four cycles
    reset = 1'b0; zone_req = 4'b0001;
    tick();
    zone_req = 4'b0000;
    chk_all("pulse_grant", 4'b0001, 4'b0000, 3'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("pulse_hold", {4'h0, zone_light}, 8'h01);
    end
    tick();
    chk_all("pulse_off", 4'b0000, 4'b0000, 3'd0);

    // All requesting: zones 0 then 1 granted, 2 and 3 wait
    do_reset();
    zone_req = 4'hF;
    tick();
    chk_all("rr_first", 4'b0001, 4'b1110, 3'd1);
    tick();
    chk_all("rr_second", 4'b0011, 4'b1100, 3'd2);
    tick();
    chk_all("rr_full", 4'b0011, 4'b1100, 3'd2);
    zone_req = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_hold0", {4'h0, zone_light}, 8'h03);
    end
    tick();
    chk_all("rr_z0_off", 4'b0010, 4'b1100, 3'd1);
    tick();
    chk_all("rr_z2_on", 4'b0110, 4'b1000, 3'd2);

    // Manual request beats an auto request waiting earlier in rr order
    do_reset();
    zone_req = 4'b0111;
    tick(2);
    chk_all("man_full", 4'b0011, 4'b0100, 3'd2);
    zone_manual = 4'b1000; zone_req = 4'b0110;
    tick(5);
    chk_all("man_z0_off", 4'b0010, 4'b1100, 3'd1);
    tick();
    chk_all("man_z3_on", 4'b1010, 4'b0100, 3'd2);

    // Bright room: auto ignored, manual still honoured
    zone_manual = 4'b0000;
    do_reset();
    lum_sen = 8'h80; zone_req = 4'hF;
    tick(2);
    chk_all("bright_auto", 4'b0000, 4'b0000, 3'd0);
    zone_manual = 4'b0100;
    tick();
    chk_all("bright_man", 4'b0100, 4'b0000, 3'd1);
    tick();
    chk("bright_man_stay", {4'h0, zone_light}, 8'h04);

    // Threshold boundary: 0x40 blocks auto, 0x3F admits it
    zone_manual = 4'b0000;
    do_reset();
    lum_sen = 8'h40; zone_req = 4'b0001;
    tick();
    chk("lum_at_thresh", {4'h0, zone_light}, 8'h00);
    lum_sen = 8'h3F;
    tick();
    chk("lum_below_thresh", {4'h0, zone_light}, 8'h01);

    // Reset during HOLD (timer at 2) drops the light on the next edge
    do_reset();
    lum_sen = 8'h10; zone_req = 4'b0010;
    tick();
    chk("hold_rst_on", {4'h0, zone_light}, 8'h02);
    zone_req = 4'b0000;
    tick(2);
    chk("hold_rst_inhold", {4'h0, zone_light}, 8'h02);
    reset = 1'b1;
    tick();
    chk_all("hold_rst", 4'b0000, 4'b0000, 3'd0);
    reset = 1'b0;
    tick();
    chk("hold_rst_after", {4'h0, zone_light}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
